alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined ALU that succeeds the single-cycle combinational ALU. Operands enter through a valid/ready handshake, pass through an operand register and a result register, and leave with registered flags; back-pressure from the consumer stalls both stages without loss. It adds signed SLT, variable shift amounts, signed overflow and a saturating completed-operation counter. It sits between the operand-issue logic and the writeback/scoreboard logic.

## Interface
- WIDTH, 8: operand/result width, ≥ 4, power of two
- CNTW, 16: width of the completed-operation counter

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- data_in1  input  WIDTH  operand A
- data_in2  input  WIDTH  operand B; low SHW = $clog2(WIDTH) bits are the shift amount for shifts
- op_code  input  3  operation select
- valid_data  input  1  operands/op_code valid this cycle
- ready_in  output  1  block accepts this cycle; transfer when valid_data & ready_in
- data_out  output  WIDTH  registered result
- valid_out  output  1  data_out and flags valid
- ready_out  input  1  consumer accepts; transfer when valid_out & ready_out
- carry_out  output  1  ADD carry / SUB borrow, else 0
- overflow_flag  output  1  signed overflow for ADD/SUB, else 0
- zero_flag  output  1  data_out == 0
- slt_flag  output  1  SLT outcome, else 0
- op_count  output  CNTW  completed output transfers, saturating

## Operation
- Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- ADD: {carry_out, data_out} = A + B, computed WIDTH+1 bits wide; overflow = A,B same sign and result sign differs.
- SUB: data_out = A − B mod 2^WIDTH; carry_out = 1 if A < B unsigned (borrow); overflow = A,B signs differ and result sign ≠ A sign.
- AND/OR/XOR: bitwise.
- SLT: signed compare; slt_flag = ($signed(A) < $signed(B)); data_out = {WIDTH−1 zeros, slt_flag}.
- SLL/SRL: A shifted left/right logically by B[SHW−1:0] (0..WIDTH−1); zeros fill; upper bits of B ignored.
- zero_flag computed for every op, SLT included.
- Two stages: S1 operand register (s1_v), S2 result+flag register (s2_v = valid_out).
- Advance enables: en2 = ~s2_v | ready_out; en1 = ~s1_v | en2; ready_in = en1 (combinational).
- en2: S2 loads compute(S1), s2_v ← s1_v. en1: S1 loads inputs, s1_v ← valid_data.
- Stalled stage holds all contents; no transfer is dropped or duplicated.
- op_count increments on each valid_out & ready_out, stops at 2^CNTW−1.

## Timing
- Reset (async assert, sync release via clk): s1_v, s2_v, data_out, all flags, op_count = 0; ready_in = 1 while in reset and after.
- Latency: accepted at edge N → valid_out high after edge N+1 (S1 at N, S2 at N+1); result visible in the cycle following N+1.
- Throughput: one op per cycle with ready_out held high.
- ready_out low with both stages full → ready_in low same cycle; two ops held.
- ready_out rising with both full → S2 drains, S1 moves up, new input accepted in the same cycle.
- valid_data low while accepting → bubble; s1_v ← 0.
- Reset mid-operation: in-flight ops discarded, op_count cleared, no output transfer.
- Inputs do not need to be stable when ready_in is low.

## Structure
- Package alu_pkg: op_code typedef enum (OP_ADD..OP_SRL), OPW = 3 constant, flag struct {carry, overflow, zero, slt}.
- Sub-module alu_core: purely combinational, WIDTH-parametrised, A/B/op → result + flag struct; alu_pipe instantiates it between S1 and S2 and owns the handshake, registers and counter.

## Test plan
- WIDTH=8, ADD 0xF0+0x20, ready_out=1 → data_out 0x10, carry 1, overflow 0, zero 0, valid_out 2 cycles after acceptance.
- SUB 0x80−0x01 → 0x7F, carry 0, overflow 1; SUB 0x05−0x05 → 0x00, zero 1.
- SLT A=0xFF B=0x01 → slt_flag 1, data_out 0x01; SLL 0x81 by B=0x0B (amount 3) → 0x08; SRL 0x81 by 7 → 0x01.
- Stream 6 ops back-to-back, ready_out low for 3 cycles mid-stream → ready_in drops once both stages full; all 6 results emerge in order, op_count = 6.
- Assert rst_n low with 2 ops in flight → valid_out, flags, op_count 0 immediately; ready_in 1; next op after release completes normally.
- CNTW=4, 17 completed transfers → op_count holds at 15.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : op codes and flag bundle shared by alu_core and alu_pipe
// Rev 1.0
// ============================================================================
package alu_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } op_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic slt;
    } flags_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational ALU datapath, result plus flag bundle
// Rev 1.0
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] result_o,
    output flags_t           flags_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [SHW-1:0]   shamt_w;
    logic             slt_w;

    assign sum_w   = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the widened difference is the unsigned borrow.
    assign diff_w  = {1'b0, a_i} - {1'b0, b_i};
    assign shamt_w = b_i[SHW-1:0];
    assign slt_w   = ($signed(a_i) < $signed(b_i));

    always_comb begin
        result_o         = '0;
        flags_o.carry    = 1'b0;
        flags_o.overflow = 1'b0;
        flags_o.slt      = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o         = sum_w[WIDTH-1:0];
                flags_o.carry    = sum_w[WIDTH];
                flags_o.overflow = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                   (sum_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                result_o         = diff_w[WIDTH-1:0];
                flags_o.carry    = diff_w[WIDTH];
                flags_o.overflow = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                                   (diff_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SLT: begin
                result_o    = {{(WIDTH-1){1'b0}}, slt_w};
                flags_o.slt = slt_w;
            end
            OP_SLL: result_o = a_i << shamt_w;
            OP_SRL: result_o = a_i >> shamt_w;
            default: result_o = '0;
        endcase
        flags_o.zero = (result_o == '0);
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : two-stage valid/ready ALU with registered flags and op counter
// Rev 1.0
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [OPW-1:0]   op_code,
    input  logic             valid_data,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             carry_out,
    output logic             overflow_flag,
    output logic             zero_flag,
    output logic             slt_flag,
    output logic [CNTW-1:0]  op_count
);

    logic [WIDTH-1:0] a_q, b_q;
    op_e              op_q;
    logic             s1_v_q;

    logic [WIDTH-1:0] res_q;
    flags_t           flags_q;
    logic             s2_v_q;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] res_d;
    flags_t           flags_d;
    logic             en1, en2;

    // A stage may advance when it is empty or the stage after it is moving.
    assign en2      = ~s2_v_q | ready_out;
    assign en1      = ~s1_v_q | en2;
    assign ready_in = en1;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (res_d),
        .flags_o  (flags_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
            s1_v_q <= 1'b0;
        end else if (en1) begin
            a_q    <= data_in1;
            b_q    <= data_in2;
            op_q   <= op_e'(op_code);
            s1_v_q <= valid_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            flags_q <= '0;
            s2_v_q  <= 1'b0;
        end else if (en2) begin
            res_q   <= res_d;
            flags_q <= flags_d;
            s2_v_q  <= s1_v_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (s2_v_q && ready_out && (cnt_q != {CNTW{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign data_out      = res_q;
    assign valid_out     = s2_v_q;
    assign carry_out     = flags_q.carry;
    assign overflow_flag = flags_q.overflow;
    assign zero_flag     = flags_q.zero;
    assign slt_flag      = flags_q.slt;
    assign op_count      = cnt_q;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe : randomized bench for alu_pipe against an arithmetic reference
// Rev 1.0
// ============================================================================
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] data_in1, data_in2;
    logic [2:0]   op_code;
    logic         valid_data, ready_out;
    logic         ready_in, valid_out;
    logic [W-1:0] data_out;
    logic         carry_out, overflow_flag, zero_flag, slt_flag;
    logic [15:0]  op_count;

    logic         s_ready_in, s_valid_out;
    logic [W-1:0] s_data_out;
    logic         s_carry, s_ovf, s_zero, s_slt;
    logic [3:0]   s_op_count;

    alu_pipe #(.WIDTH(W), .CNTW(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .data_in1(data_in1), .data_in2(data_in2), .op_code(op_code),
        .valid_data(valid_data), .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .carry_out(carry_out), .overflow_flag(overflow_flag),
        .zero_flag(zero_flag), .slt_flag(slt_flag), .op_count(op_count)
    );

    alu_pipe #(.WIDTH(W), .CNTW(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .data_in1(data_in1), .data_in2(data_in2), .op_code(op_code),
        .valid_data(valid_data), .ready_in(s_ready_in),
        .data_out(s_data_out), .valid_out(s_valid_out), .ready_out(ready_out),
        .carry_out(s_carry), .overflow_flag(s_ovf),
        .zero_flag(s_zero), .slt_flag(s_slt), .op_count(s_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int res;
        int c;
        int v;
        int z;
        int s;
        int acc;
    } item_t;

    item_t q[$];
    int    n_checks  = 0;
    int    n_fail    = 0;
    int    edges     = 0;
    int    cnt16     = 0;
    int    cnt4      = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int sval(input int x);
        return (x >= 2**(W-1)) ? x - 2**W : x;
    endfunction

    // Reference computed with plain integer arithmetic.
    function automatic item_t model(input int a, input int b, input int op);
        item_t r;
        int    full;
        int    sres;
        r = '{0, 0, 0, 0, 0, 0};
        case (op)
            0: begin
                full  = a + b;
                r.res = full % (2**W);
                r.c   = (full >= 2**W) ? 1 : 0;
                sres  = sval(a) + sval(b);
                r.v   = (sres > 2**(W-1) - 1 || sres < -(2**(W-1))) ? 1 : 0;
            end
            1: begin
                r.res = (a - b + 2**W) % (2**W);
                r.c   = (a < b) ? 1 : 0;
                sres  = sval(a) - sval(b);
                r.v   = (sres > 2**(W-1) - 1 || sres < -(2**(W-1))) ? 1 : 0;
            end
            2: r.res = a & b;
            3: r.res = a | b;
            4: r.res = a ^ b;
            5: begin
                r.s   = (sval(a) < sval(b)) ? 1 : 0;
                r.res = r.s;
            end
            6: r.res = (a * (2**(b % W))) % (2**W);
            default: r.res = a / (2**(b % W));
        endcase
        r.z = (r.res == 0) ? 1 : 0;
        return r;
    endfunction

    // One cycle: drive at negedge, check mid-cycle, update model for the next posedge.
    task automatic step(input int v, input int a, input int b, input int op,
                        input int ro, output int accepted);
        item_t it;
        int    exp_vo;
        valid_data = v[0];
        data_in1   = a[W-1:0];
        data_in2   = b[W-1:0];
        op_code    = op[2:0];
        ready_out  = ro[0];
        #1;
        exp_vo = (q.size() > 0 && edges >= q[0].acc + 1) ? 1 : 0;
        chk("ready_in", int'(ready_in), (q.size() == 2 && ro == 0) ? 0 : 1);
        chk("valid_out", int'(valid_out), exp_vo);
        chk("op_count", int'(op_count), cnt16);
        chk("op_count_sat", int'(s_op_count), cnt4);
        if (valid_out && ro != 0) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                it = q.pop_front();
                chk("data_out", int'(data_out), it.res);
                chk("carry_out", int'(carry_out), it.c);
                chk("overflow", int'(overflow_flag), it.v);
                chk("zero_flag", int'(zero_flag), it.z);
                chk("slt_flag", int'(slt_flag), it.s);
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
        end
        accepted = (v != 0 && ready_in) ? 1 : 0;
        if (accepted != 0) begin
            it     = model(a, b, op);
            it.acc = edges + 1;
            q.push_back(it);
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    int dir_a  [6] = '{'hF0, 'h80, 'h05, 'hFF, 'h81, 'h81};
    int dir_b  [6] = '{'h20, 'h01, 'h05, 'h01, 'h0B, 'h07};
    int dir_op [6] = '{0, 1, 1, 5, 6, 7};

    initial begin
        int acc;
        int idx;
        int guard;
        rst_n      = 1'b0;
        valid_data = 1'b0;
        data_in1   = '0;
        data_in2   = '0;
        op_code    = '0;
        ready_out  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_flags", int'({carry_out, overflow_flag, zero_flag, slt_flag}), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_ready_in", int'(ready_in), 1);
        rst_n = 1'b1;

        // Directed vectors, one op per cycle.
        for (int i = 0; i < 6; i++) step(1, dir_a[i], dir_b[i], dir_op[i], 1, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);

        // Six back-to-back ops with a three-cycle consumer stall.
        idx   = 0;
        guard = 0;
        while ((idx < 6 || q.size() > 0) && guard < 40) begin
            step((idx < 6) ? 1 : 0, $urandom_range(255), $urandom_range(255),
                 idx % 8, (guard >= 2 && guard < 5) ? 0 : 1, acc);
            if (acc != 0) idx++;
            guard++;
        end
        chk("stream_drained", q.size(), 0);
        chk("stream_count", int'(op_count), 12);

        // Reset with two ops in flight.
        step(1, 3, 4, 0, 0, acc);
        step(1, 9, 2, 1, 0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_out", int'(valid_out), 0);
        chk("mid_rst_flags", int'({carry_out, overflow_flag, zero_flag, slt_flag}), 0);
        chk("mid_rst_op_count", int'(op_count), 0);
        chk("mid_rst_ready_in", int'(ready_in), 1);
        q.delete();
        cnt16 = 0;
        cnt4  = 0;
        @(posedge clk);
        edges++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 'h10, 'h22, 2, 1, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);
        chk("post_rst_count", int'(op_count), 1);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(3) != 0) ? 1 : 0, $urandom_range(255), $urandom_range(255),
                 $urandom_range(7), ($urandom_range(3) != 0) ? 1 : 0, acc);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, acc);
        chk("final_drained", q.size(), 0);
        chk("final_sat", int'(s_op_count), 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_pipe
`default_nettype wire
